coeff_token_encoder: RTL and testbench
======================================

Name: coeff_token_encoder

Overview:
- CAVLC coeff_token encoder and bit packer; the transmit-side counterpart of the coeff_token decode path.
- Accepts one (TotalCoeff, TrailingOnes, nC) token per handshake and looks up the H.264 Table 9-5 codeword for the nC class.
- Appends the codeword MSB-first into a bit accumulator and emits packed 16-bit words over a valid/ready interface.
- Sits between the residual-block scan logic and the slice bitstream writer.

Parameters:
- WORD_W, 16, output word width in bits; only 16 is supported.
- ACC_W, 32, accumulator width; must be >= WORD_W + 16.

Ports:
- Clk  input  1  clock
- nReset  input  1  reset, asynchronous, active-low
- InValid  input  1  token valid
- InReady  output  1  token accepted when InValid && InReady
- TotalCoeff  input  5  0..16
- TrailingOnes  input  2  0..3
- nC  input  5  0..16 = luma/AC nC; 5'b11110 = chroma DC 4:2:0 (nC -1); 5'b11111 = chroma DC 4:2:2 (nC -2)
- Flush  input  1  pad and emit partial word; sampled only with InValid && InReady, token fields ignored that cycle
- OutValid  output  1  OutWord valid
- OutReady  input  1  downstream accepts OutWord
- OutWord  output  16  packed bits, first bit in bit 15
- Idle  output  1  fill == 0 and FSM in ACTIVE
- Error  output  1  sticky illegal-token flag

Behaviour:
- Reset: InReady=0, OutValid=0, OutWord=0, Idle=0, Error=0, fill=0, accumulator=0, FSM=RESET. First clock after reset release moves the FSM to ACTIVE (InReady=1, Idle=1).
- Lookup is combinational on the inputs; the codeword table is selected by nC class: 0-1, 2-3, 4-7, 8-16, 11110, 11111.
- nC 8..16 class uses the 6-bit fixed-length code {TotalCoeff-1[3:0], TrailingOnes}; TotalCoeff=0 encodes as 000011.
- Codeword length is 1..16; the codeword is left-aligned at bit position (ACC_W-1-fill) in the accumulator.
- Illegal token, which is dropped (accepted but no bits appended) and sets Error until reset:
  - TrailingOnes > TotalCoeff, or TrailingOnes == 3 with TotalCoeff < 3;
  - TotalCoeff > 16;
  - TotalCoeff > 4 for nC 11110;
  - TotalCoeff > 8 for nC 11111;
  - nC in 17..29.
- InReady = (FSM == ACTIVE) && (fill < 16), registered.
- Latency: a token accepted in cycle N updates fill in cycle N+1; if fill >= 16 after the update, OutValid rises in cycle N+1.
- OutValid = fill >= 16 (or FLUSH with fill > 0); OutWord = accumulator[ACC_W-1 -: 16].
- On OutValid && OutReady: accumulator shifts left by 16 (zero-fill); fill -= 16 (or fill = 0 in FLUSH).
- Accept and drain in the same cycle: drain is applied first, then the append at the post-drain fill. The new fill is always <= 31.
- OutValid/OutWord are held stable while OutReady=0.
- FSM states:
  - ACTIVE: accepting tokens.
  - FLUSH: entered on an accepted Flush; InReady=0. If fill == 0, return to ACTIVE the next cycle with no word emitted. Otherwise emit remaining words; the last one has zero padding in its low bits. Return to ACTIVE after the final word is accepted.
  - RESET: one-cycle post-reset state.
- Reset asserted mid-operation discards all buffered bits; no partial word is emitted.
- Idle is 1 only in ACTIVE with fill == 0.

Optional Feature:
- Macro COEFF_TOKEN_BITCOUNT_EN.
- When defined: adds output port BitCount (output, 32 bits, reset 0).
  - Increments by the codeword length on every accepted legal token.
  - Wraps modulo 2^32.
  - Padding bits and dropped tokens are not counted.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then nC=0 tokens (0,0),(1,1),(2,2) followed by Flush, OutReady=1 -> one word 16'b1010_0100_0000_0000 (codes 1,01,001, padded); Idle=1 after.
- nC=8 with tokens (0,0) then (16,3), repeated until 16 bits accumulated, OutReady=1 -> first word bits 000011_111111 followed by the next codes; OutValid in the cycle after the token that crosses 16 bits.
- nC=5'b11110 with (0,0),(1,1) then Flush -> word 16'b0110_0000_0000_0000; nC=5'b11111 with TotalCoeff=9 -> Error=1, no bits appended.
- Hold OutReady=0 with fill >= 16 -> InReady=0, OutWord stable for 10 cycles; raise OutReady -> word drained, InReady returns next cycle.
- Stream of 16-bit codewords (nC=0, (13,3)-class long codes) with random OutReady -> no bit loss against a golden bitstring; fill never exceeds 31.
- nReset asserted with fill=10 mid-stream -> all outputs at reset values, and the first word after recovery contains only post-reset tokens; with COEFF_TOKEN_BITCOUNT_EN, BitCount=0 after reset and equals the summed code lengths after the stream.

Source files
------------

// File: rtl/coeff_token_encoder.sv
// CAVLC coeff_token encoder: Table 9-5 lookup plus 16-bit MSB-first packer.
// Optional BitCount output is enabled by COEFF_TOKEN_BITCOUNT_EN.
module coeff_token_encoder #(
    parameter int WORD_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [4:0]        TotalCoeff,
    input  logic [1:0]        TrailingOnes,
    input  logic [4:0]        nC,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [WORD_W-1:0] OutWord,
    output logic              Idle,
    output logic              Error
`ifdef COEFF_TOKEN_BITCOUNT_EN
    ,
    output logic [31:0]       BitCount
`endif
);

    // Tables indexed by {TotalCoeff, TrailingOnes}; code is right-aligned.
    localparam logic [4:0] L0 [0:67] = '{
        1,0,0,0, 6,2,0,0, 8,6,3,0, 9,8,7,5, 10,9,8,6, 11,10,9,7,
        13,11,10,8, 13,13,11,9, 13,13,13,10, 14,14,13,11, 14,14,14,13,
        15,15,14,14, 15,15,15,14, 16,15,15,15, 16,16,16,15,
        16,16,16,16, 16,16,16,16};
    localparam logic [3:0] B0 [0:67] = '{
        1,0,0,0, 5,1,0,0, 7,4,1,0, 7,6,5,3, 7,6,5,3, 7,6,5,4,
        15,6,5,4, 11,14,5,4, 8,10,13,4, 15,14,9,4, 11,10,13,12,
        15,14,9,12, 11,10,13,8, 15,1,9,12, 11,14,13,8,
        7,10,9,12, 4,6,5,8};
    localparam logic [4:0] L1 [0:67] = '{
        2,0,0,0, 6,2,0,0, 6,5,3,0, 7,6,6,4, 8,6,6,4, 8,7,7,5,
        9,8,8,6, 11,9,9,6, 11,11,11,7, 12,11,11,9, 12,12,12,11,
        12,12,12,11, 13,13,13,12, 13,13,13,13, 13,14,13,13,
        14,14,14,13, 14,14,14,14};
    localparam logic [3:0] B1 [0:67] = '{
        3,0,0,0, 11,2,0,0, 7,7,3,0, 7,10,9,5, 7,6,5,4, 4,6,5,6,
        7,6,5,8, 15,6,5,4, 11,14,13,4, 15,10,9,4, 11,14,13,12,
        8,10,9,8, 15,14,13,12, 11,10,9,12, 7,11,6,8,
        9,8,10,1, 7,6,5,4};
    localparam logic [4:0] L2 [0:67] = '{
        4,0,0,0, 6,4,0,0, 6,5,4,0, 6,5,5,4, 7,5,5,4, 7,5,5,4,
        7,6,6,4, 7,6,6,4, 8,7,7,5, 8,8,7,6, 9,8,8,7,
        9,9,8,8, 9,9,9,8, 10,9,9,9, 10,10,10,10,
        10,10,10,10, 10,10,10,10};
    localparam logic [3:0] B2 [0:67] = '{
        15,0,0,0, 15,14,0,0, 11,15,13,0, 8,12,14,12, 15,10,11,11,
        11,8,9,10, 9,14,13,9, 8,10,9,8, 15,14,13,13, 11,14,10,12,
        15,10,13,12, 11,14,9,12, 8,10,13,8, 13,7,9,12,
        9,12,11,10, 5,8,7,6, 1,4,3,2};
    localparam logic [4:0] LC1 [0:19] = '{
        2,0,0,0, 6,1,0,0, 6,6,3,0, 6,7,7,6, 6,8,8,7};
    localparam logic [3:0] BC1 [0:19] = '{
        1,0,0,0, 7,1,0,0, 4,6,1,0, 3,3,2,5, 2,3,2,0};
    localparam logic [4:0] LC2 [0:35] = '{
        1,0,0,0, 7,2,0,0, 7,7,3,0, 9,7,7,5, 9,9,7,6,
        10,10,9,7, 11,11,10,7, 12,12,11,10, 13,12,12,11};
    localparam logic [3:0] BC2 [0:35] = '{
        1,0,0,0, 15,1,0,0, 14,13,1,0, 7,12,11,1, 6,5,10,1,
        7,6,4,9, 7,6,5,8, 7,6,5,4, 7,5,4,4};

    typedef enum logic [1:0] {S_RESET, S_ACTIVE, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [4:0]         fill_q, fill_d;
    logic               inrdy_q, inrdy_d;
    logic               err_q, err_d;

    logic [6:0]         idx;
    logic [3:0]         tc_m1;
    logic               legal;
    logic [4:0]         len;
    logic [WORD_W-1:0]  code;
    logic [WORD_W-1:0]  code_l;
    logic [ACC_W-1:0]   placed;
    logic               accept;
    logic               drain;

    assign idx    = {TotalCoeff, TrailingOnes};
    assign tc_m1  = TotalCoeff[3:0] - 4'd1;
    assign code_l = code << (5'd16 - len);
    assign placed = {code_l, {(ACC_W-WORD_W){1'b0}}};

    // Codeword lookup and legality check, selected by nC class.
    always_comb begin
        len   = '0;
        code  = '0;
        legal = ({3'b0, TrailingOnes} <= TotalCoeff) &&
                (TotalCoeff <= 5'd16);
        unique case (1'b1)
            (nC <= 5'd1): if (legal) begin
                len  = L0[idx];
                code = {12'd0, B0[idx]};
            end
            (nC >= 5'd2 && nC <= 5'd3): if (legal) begin
                len  = L1[idx];
                code = {12'd0, B1[idx]};
            end
            (nC >= 5'd4 && nC <= 5'd7): if (legal) begin
                len  = L2[idx];
                code = {12'd0, B2[idx]};
            end
            (nC >= 5'd8 && nC <= 5'd16): if (legal) begin
                len  = 5'd6;
                code = (TotalCoeff == 5'd0) ? 16'd3
                     : {10'd0, tc_m1, TrailingOnes};
            end
            (nC == 5'd30): begin
                legal = legal && (TotalCoeff <= 5'd4);
                if (legal) begin
                    len  = LC1[idx[4:0]];
                    code = {12'd0, BC1[idx[4:0]]};
                end
            end
            (nC == 5'd31): begin
                legal = legal && (TotalCoeff <= 5'd8);
                if (legal) begin
                    len  = LC2[idx[5:0]];
                    code = {12'd0, BC2[idx[5:0]]};
                end
            end
            default: legal = 1'b0;
        endcase
    end

    assign accept   = InValid && inrdy_q;
    assign OutValid = (fill_q >= 5'd16) ||
                      ((state_q == S_FLUSH) && (fill_q != 5'd0));
    assign drain    = OutValid && OutReady;
    assign OutWord  = acc_q[ACC_W-1 -: WORD_W];
    assign InReady  = inrdy_q;
    assign Idle     = (state_q == S_ACTIVE) && (fill_q == 5'd0);
    assign Error    = err_q;

    // Drain first, then append the accepted codeword at the new fill.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        err_d   = err_q;
        if (drain) begin
            acc_d  = acc_q << WORD_W;
            fill_d = (state_q == S_FLUSH) ? 5'd0 : fill_q - 5'd16;
        end
        unique case (state_q)
            S_RESET:  state_d = S_ACTIVE;
            S_ACTIVE: if (accept) begin
                if (Flush) begin
                    state_d = S_FLUSH;
                end else if (legal) begin
                    acc_d  = acc_d | (placed >> fill_d);
                    fill_d = fill_d + len;
                end else begin
                    err_d = 1'b1;
                end
            end
            S_FLUSH:  if (fill_q == 5'd0 || drain) state_d = S_ACTIVE;
            default:  state_d = S_RESET;
        endcase
        inrdy_d = (state_d == S_ACTIVE) && (fill_d < 5'd16);
    end

    // State, accumulator and handshake registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_RESET;
            acc_q   <= '0;
            fill_q  <= '0;
            inrdy_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            inrdy_q <= inrdy_d;
            err_q   <= err_d;
        end
    end

`ifdef COEFF_TOKEN_BITCOUNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Running total of emitted codeword bits, padding excluded.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ACTIVE && accept && !Flush && legal)
            cnt_d = cnt_q + {27'd0, len};
    end

    // Bit counter register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign BitCount = cnt_q;
`endif

endmodule

// File: tb/tb_coeff_token_encoder.sv
// Directed bench for coeff_token_encoder.
// Expected words are hand-packed from Table 9-5 codewords.
module tb_coeff_token_encoder;

    logic        Clk;
    logic        nReset;
    logic        InValid;
    logic        InReady;
    logic [4:0]  TotalCoeff;
    logic [1:0]  TrailingOnes;
    logic [4:0]  nC;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] OutWord;
    logic        Idle;
    logic        Error;
`ifdef COEFF_TOKEN_BITCOUNT_EN
    logic [31:0] BitCount;
`endif

    coeff_token_encoder dut (
        .Clk(Clk), .nReset(nReset),
        .InValid(InValid), .InReady(InReady),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes),
        .nC(nC), .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutWord(OutWord), .Idle(Idle), .Error(Error)
`ifdef COEFF_TOKEN_BITCOUNT_EN
        , .BitCount(BitCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Stream: (1,1)=01 then twelve 16-bit nC=0 codewords.
    localparam logic [4:0]  S_TC [0:12] = '{
        1, 13, 14, 14, 14, 15, 15, 15, 15, 16, 16, 16, 16};
    localparam logic [1:0]  S_T1 [0:12] = '{
        1, 0, 0, 1, 2, 0, 1, 2, 3, 0, 1, 2, 3};
    localparam logic [15:0] S_CODE [0:12] = '{
        16'h1, 16'hF, 16'hB, 16'hE, 16'hD, 16'h7, 16'hA,
        16'h9, 16'hC, 16'h4, 16'h6, 16'h5, 16'h8};
    localparam int S_LEN [0:12] = '{
        2, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16};

    logic [255:0] gold;
    int           gb;
    logic [15:0]  got [0:15];
    int           nw;
    logic [15:0]  w;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [4:0] tc, input logic [1:0] t1,
                        input logic [4:0] n, input logic fl);
        int k;
        TotalCoeff   = tc;
        TrailingOnes = t1;
        nC           = n;
        Flush        = fl;
        InValid      = 1'b1;
        k = 0;
        while (!InReady && k < 200) begin
            tick();
            k++;
        end
        if (!InReady) check("send_timeout", 32'(InReady), 32'd1);
        tick();
        InValid    = 1'b0;
        Flush      = 1'b0;
        TotalCoeff = '0;
        TrailingOnes = '0;
        nC         = '0;
    endtask

    task automatic recv(output logic [15:0] word);
        int k;
        OutReady = 1'b1;
        k = 0;
        while (!OutValid && k < 200) begin
            tick();
            k++;
        end
        if (!OutValid) check("recv_timeout", 32'(OutValid), 32'd1);
        word = OutWord;
        tick();
        OutReady = 1'b0;
    endtask

    initial begin
        nReset = 1'b0;
        InValid = 1'b0;
        TotalCoeff = '0;
        TrailingOnes = '0;
        nC = '0;
        Flush = 1'b0;
        OutReady = 1'b0;
        tick();
        tick();
        check("reset_outs",
              32'({InReady, OutValid, OutWord, Idle, Error}), 32'd0);
        nReset = 1'b1;
        tick();
        check("post_reset_active", 32'({InReady, Idle}), 32'b11);
`ifdef COEFF_TOKEN_BITCOUNT_EN
        check("bitcount_reset", BitCount, 32'd0);
`endif

        // nC=0: 1 01 001, padded
        send(5'd0, 2'd0, 5'd0, 1'b0);
        send(5'd1, 2'd1, 5'd0, 1'b0);
        send(5'd2, 2'd2, 5'd0, 1'b0);
        check("t1_no_early_valid", 32'(OutValid), 32'd0);
        send(5'd0, 2'd0, 5'd0, 1'b1);
        recv(w);
        check("t1_word", 32'(w), 32'h0000A400);
        check("t1_idle", 32'(Idle), 32'd1);

        // nC=8 FLC: 000011 111111 000011
        send(5'd0, 2'd0, 5'd8, 1'b0);
        send(5'd16, 2'd3, 5'd8, 1'b0);
        check("t2_below16", 32'(OutValid), 32'd0);
        send(5'd0, 2'd0, 5'd8, 1'b0);
        check("t2_latency", 32'(OutValid), 32'd1);
        check("t2_inready_low", 32'(InReady), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold", 32'({OutValid, InReady, OutWord}),
                  {14'd0, 2'b10, 16'h0FF0});
            tick();
        end
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        check("t2_drained", 32'({OutValid, InReady}), 32'b01);
        send(5'd0, 2'd0, 5'd0, 1'b1);
        recv(w);
        check("t2_tail", 32'(w), 32'h0000C000);
        check("t2_idle", 32'(Idle), 32'd1);

        // Chroma DC 4:2:0: 01 1
        send(5'd0, 2'd0, 5'd30, 1'b0);
        send(5'd1, 2'd1, 5'd30, 1'b0);
        send(5'd0, 2'd0, 5'd0, 1'b1);
        recv(w);
        check("t3_cdc_word", 32'(w), 32'h00006000);

        // nC=2 (1,0)=001011, nC=4 (0,0)=1111, nC=-2 (1,0)=0001111
        send(5'd1, 2'd0, 5'd2, 1'b0);
        send(5'd0, 2'd0, 5'd4, 1'b0);
        send(5'd1, 2'd0, 5'd31, 1'b0);
        check("t3_mix_valid", 32'(OutValid), 32'd1);
        recv(w);
        check("t3_mix_word", 32'(w), 32'h00002FC7);
        send(5'd0, 2'd0, 5'd0, 1'b1);
        recv(w);
        check("t3_mix_tail", 32'(w), 32'h00008000);

        // Flush with nothing buffered
        send(5'd0, 2'd0, 5'd0, 1'b1);
        check("t4_empty_flush", 32'({OutValid, InReady}), 32'b00);
        tick();
        check("t4_empty_back", 32'({InReady, Idle}), 32'b11);

        // Long codes with random backpressure
        gold = '0;
        gb = 0;
        for (int k = 0; k < 13; k++) begin
            for (int i = 0; i < S_LEN[k]; i++)
                gold[255-gb-i] = S_CODE[k][S_LEN[k]-1-i];
            gb += S_LEN[k];
        end
        nw = 0;
        fork
            begin
                for (int k = 0; k < 13; k++)
                    send(S_TC[k], S_T1[k], 5'd0, 1'b0);
                send(5'd0, 2'd0, 5'd0, 1'b1);
            end
            begin
                for (int c = 0; c < 3000 && nw < 13; c++) begin
                    OutReady = 1'($urandom_range(0, 1));
                    if (OutValid && OutReady) begin
                        got[nw] = OutWord;
                        nw++;
                    end
                    tick();
                end
                OutReady = 1'b0;
            end
        join
        check("t5_word_count", 32'(nw), 32'd13);
        for (int k = 0; k < 13; k++)
            check("t5_stream_word", 32'(got[k]),
                  32'(gold[255-16*k -: 16]));
        tick();
        check("t5_idle", 32'(Idle), 32'd1);

        // Illegal tokens
        check("t6_no_error", 32'(Error), 32'd0);
        send(5'd9, 2'd0, 5'd31, 1'b0);
        check("t6_err_cdc422", 32'({Error, Idle, OutValid}), 32'b110);

        // Reset with 10 bits buffered: 000101 1111
        send(5'd1, 2'd0, 5'd0, 1'b0);
        send(5'd0, 2'd0, 5'd4, 1'b0);
        check("t7_fill10", 32'({OutValid, Idle}), 32'b00);
        nReset = 1'b0;
        #1;
        check("t7_reset_outs",
              32'({InReady, OutValid, OutWord, Idle, Error}), 32'd0);
        tick();
        nReset = 1'b1;
        tick();
        check("t7_recovered", 32'({InReady, Idle, Error}), 32'b110);
        send(5'd2, 2'd2, 5'd0, 1'b0);
        send(5'd0, 2'd0, 5'd0, 1'b1);
        recv(w);
        check("t7_clean_word", 32'(w), 32'h00002000);
        send(5'd1, 2'd0, 5'd20, 1'b0);
        check("t7_err_nc20", 32'({Error, Idle}), 32'b11);
`ifdef COEFF_TOKEN_BITCOUNT_EN
        check("bitcount_sum", BitCount, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
